ulpb_power_sequencer: RTL and testbench
=======================================

// Module: ulpb_power_sequencer
// PURPOSE
//  Always-on sequencer that drives the POWER_ON / RELEASE_CLK / RELEASE_RST / RELEASE_ISO
//  controls consumed by the node isolation block and layer controller. Orders power-up
//  (power, clock, reset, isolation) and power-down (reverse order) with programmable gaps.
//  Sits in the always-on domain beside the bus controller. Never power-gated.
// PARAMETERS
//  CNT_WIDTH  4  width of the step-delay counter; every *_DLY must be < 2**CNT_WIDTH
//  PWR_DLY    3  extra cycles after POWER_ON edge before the next step (hold = PWR_DLY+1)
//  CLK_DLY    2  extra cycles after RELEASE_CLK edge before the next step
//  RST_DLY    2  extra cycles after RELEASE_RST edge before the next step
//  ISO_DLY    1  extra cycles after RELEASE_ISO falls before RELEASE_RST falls (sleep path)
// PORTS
//  CLK          in   1  always-on clock
//  RESET        in   1  asynchronous reset, active-high
//  WAKEUP_REQ   in   1  request wake; sampled on CLK rising edge
//  SLEEP_REQ    in   1  request sleep; sampled on CLK rising edge
//  POWER_ON     out  1  1 = layer power domain on
//  RELEASE_CLK  out  1  1 = layer clock running
//  RELEASE_RST  out  1  1 = layer reset released
//  RELEASE_ISO  out  1  1 = isolation released (layer outputs pass through)
//  WAKE_DONE    out  1  1-cycle pulse, same cycle RELEASE_ISO rises
//  SLEEP_DONE   out  1  1-cycle pulse, same cycle POWER_ON falls
//  BUSY         out  1  1 in any state other than ASLEEP and ACTIVE
// BEHAVIOUR
//  - All outputs are registered. On RESET (async): state=ASLEEP, all outputs 0, counter 0,
//    pending flags cleared. Reset mid-sequence drops every control to 0 at once.
//  - States: ASLEEP, PWR_UP, CLK_UP, RST_UP, ACTIVE, ISO_DN, RST_DN, CLK_DN.
//  - Step wait: on entering a wait state the counter loads 0, increments each cycle, and
//    advances when counter == *_DLY; so each gap = *_DLY+1 cycles.
//  - ASLEEP: WAKEUP_REQ=1 -> PWR_UP, POWER_ON=1 next cycle. SLEEP_REQ ignored.
//  - PWR_UP: after PWR_DLY+1 cycles -> CLK_UP, RELEASE_CLK=1.
//  - CLK_UP: after CLK_DLY+1 cycles -> RST_UP, RELEASE_RST=1.
//  - RST_UP: after RST_DLY+1 cycles -> ACTIVE, RELEASE_ISO=1, WAKE_DONE=1 for one cycle.
//  - ACTIVE: SLEEP_REQ=1 -> ISO_DN, RELEASE_ISO=0 next cycle. WAKEUP_REQ ignored.
//  - ISO_DN: after ISO_DLY+1 cycles -> RST_DN, RELEASE_RST=0.
//  - RST_DN: after RST_DLY+1 cycles -> CLK_DN, RELEASE_CLK=0.
//  - CLK_DN: after CLK_DLY+1 cycles -> ASLEEP, POWER_ON=0, SLEEP_DONE=1 for one cycle.
//  - Invariants: RELEASE_ISO=1 implies RELEASE_RST=1 implies RELEASE_CLK=1 implies
//    POWER_ON=1. At most one control output changes per cycle.
//  - Opposing request mid-sequence: the sequence is never aborted. SLEEP_REQ during
//    PWR_UP/CLK_UP/RST_UP sets sleep_pend; WAKEUP_REQ during ISO_DN/RST_DN/CLK_DN sets
//    wake_pend. On reaching ACTIVE (resp. ASLEEP), a set pend flag starts the opposite
//    sequence on the next edge and is cleared. The DONE pulse still fires.
//  - Same-direction request during a sequence: no effect. A same-direction request also
//    clears the opposite pend flag, so the last request wins.
//  - WAKEUP_REQ and SLEEP_REQ high together: in ASLEEP wake wins; in ACTIVE sleep wins.
//    During a sequence, both requests together leave the pend flags unchanged.
//  - Latency: request edge to first control edge = 1 cycle. Full wake = 1+PWR_DLY+1+
//    CLK_DLY+1+RST_DLY+1 cycles to RELEASE_ISO.
// TESTING (defaults; request high for one cycle, sampled at edge 0)
//  - Wake from reset -> POWER_ON@1, RELEASE_CLK@5, RELEASE_RST@8, RELEASE_ISO+WAKE_DONE@11.
//  - Sleep from ACTIVE -> RELEASE_ISO=0@1, RELEASE_RST=0@3, RELEASE_CLK=0@6,
//    POWER_ON=0+SLEEP_DONE@9.
//  - SLEEP_REQ at edge 3 of a wake -> wake completes @11, RELEASE_ISO falls @12,
//    BUSY stays 1 throughout.
//  - WAKEUP_REQ in ACTIVE and SLEEP_REQ in ASLEEP -> no output change, BUSY=0.
//  - RESET asserted @6 of a wake -> all outputs 0 asynchronously.
//    WAKEUP_REQ after release restarts from POWER_ON.
//  - Random request stream (1k cycles) -> assertion: ordering invariant holds every cycle.

Source files
------------

// File: rtl/ulpb_power_sequencer.sv
`default_nettype none
// ============================================================================
// ulpb_power_sequencer : always-on power/clock/reset/isolation sequencer
// Revision 1.0 - initial release
// ============================================================================
module ulpb_power_sequencer #(
  parameter int CNT_WIDTH = 4,
  parameter int PWR_DLY   = 3,
  parameter int CLK_DLY   = 2,
  parameter int RST_DLY   = 2,
  parameter int ISO_DLY   = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic WAKEUP_REQ,
  input  logic SLEEP_REQ,
  output logic POWER_ON,
  output logic RELEASE_CLK,
  output logic RELEASE_RST,
  output logic RELEASE_ISO,
  output logic WAKE_DONE,
  output logic SLEEP_DONE,
  output logic BUSY
);

  typedef enum logic [2:0] {
    ASLEEP = 3'd0,
    PWR_UP = 3'd1,
    CLK_UP = 3'd2,
    RST_UP = 3'd3,
    ACTIVE = 3'd4,
    ISO_DN = 3'd5,
    RST_DN = 3'd6,
    CLK_DN = 3'd7
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_PWR_DLY = CNT_WIDTH'(PWR_DLY);
  localparam logic [CNT_WIDTH-1:0] C_CLK_DLY = CNT_WIDTH'(CLK_DLY);
  localparam logic [CNT_WIDTH-1:0] C_RST_DLY = CNT_WIDTH'(RST_DLY);
  localparam logic [CNT_WIDTH-1:0] C_ISO_DLY = CNT_WIDTH'(ISO_DLY);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH-1:0] w_dly;
  logic                 r_wake_pend;
  logic                 r_sleep_pend;
  logic                 w_wake_pend_next;
  logic                 w_sleep_pend_next;
  logic                 w_step_done;
  logic                 w_wake_only;
  logic                 w_sleep_only;

  logic w_power_on;
  logic w_release_clk;
  logic w_release_rst;
  logic w_release_iso;
  logic w_busy;

  assign w_wake_only  = WAKEUP_REQ & ~SLEEP_REQ;
  assign w_sleep_only = SLEEP_REQ & ~WAKEUP_REQ;

  // Gap length for the current wait state; idle states never consult it
  always_comb begin
    w_dly = '0;
    case (r_state)
      PWR_UP:         w_dly = C_PWR_DLY;
      CLK_UP, CLK_DN: w_dly = C_CLK_DLY;
      RST_UP, RST_DN: w_dly = C_RST_DLY;
      ISO_DN:         w_dly = C_ISO_DLY;
      default:        w_dly = '0;
    endcase
  end

  assign w_step_done = (r_cnt == w_dly);

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt + C_CNT_ONE;
    w_wake_pend_next  = r_wake_pend;
    w_sleep_pend_next = r_sleep_pend;

    case (r_state)
      ASLEEP: begin
        w_cnt_next        = '0;
        w_sleep_pend_next = 1'b0;
        if (WAKEUP_REQ || r_wake_pend) begin
          w_state_next     = PWR_UP;
          w_wake_pend_next = 1'b0;
        end
      end

      ACTIVE: begin
        w_cnt_next       = '0;
        w_wake_pend_next = 1'b0;
        if (SLEEP_REQ || r_sleep_pend) begin
          w_state_next      = ISO_DN;
          w_sleep_pend_next = 1'b0;
        end
      end

      PWR_UP, CLK_UP, RST_UP: begin
        // Wake sequence runs to completion; a lone request only edits the pend flag
        if (w_sleep_only) begin
          w_sleep_pend_next = 1'b1;
        end else if (w_wake_only) begin
          w_sleep_pend_next = 1'b0;
        end
        if (w_step_done) begin
          w_cnt_next = '0;
          case (r_state)
            PWR_UP:  w_state_next = CLK_UP;
            CLK_UP:  w_state_next = RST_UP;
            default: w_state_next = ACTIVE;
          endcase
        end
      end

      default: begin
        if (w_wake_only) begin
          w_wake_pend_next = 1'b1;
        end else if (w_sleep_only) begin
          w_wake_pend_next = 1'b0;
        end
        if (w_step_done) begin
          w_cnt_next = '0;
          case (r_state)
            ISO_DN:  w_state_next = RST_DN;
            RST_DN:  w_state_next = CLK_DN;
            default: w_state_next = ASLEEP;
          endcase
        end
      end
    endcase
  end

  // Control levels implied by the current state; registered one cycle later
  always_comb begin
    w_power_on    = (r_state != ASLEEP);
    w_release_clk = 1'b0;
    w_release_rst = 1'b0;
    w_release_iso = (r_state == ACTIVE);
    case (r_state)
      CLK_UP, RST_DN:         w_release_clk = 1'b1;
      RST_UP, ACTIVE, ISO_DN: begin
        w_release_clk = 1'b1;
        w_release_rst = 1'b1;
      end
      default: begin
        w_release_clk = 1'b0;
        w_release_rst = 1'b0;
      end
    endcase
    w_busy = ((r_state != ASLEEP) && (r_state != ACTIVE)) ||
             ((r_state == ASLEEP) && r_wake_pend) ||
             ((r_state == ACTIVE) && r_sleep_pend);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ASLEEP;
      r_cnt        <= '0;
      r_wake_pend  <= 1'b0;
      r_sleep_pend <= 1'b0;
      POWER_ON     <= 1'b0;
      RELEASE_CLK  <= 1'b0;
      RELEASE_RST  <= 1'b0;
      RELEASE_ISO  <= 1'b0;
      WAKE_DONE    <= 1'b0;
      SLEEP_DONE   <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_wake_pend  <= w_wake_pend_next;
      r_sleep_pend <= w_sleep_pend_next;
      POWER_ON     <= w_power_on;
      RELEASE_CLK  <= w_release_clk;
      RELEASE_RST  <= w_release_rst;
      RELEASE_ISO  <= w_release_iso;
      WAKE_DONE    <= w_release_iso & ~RELEASE_ISO;
      SLEEP_DONE   <= ~w_power_on & POWER_ON;
      BUSY         <= w_busy;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ulpb_power_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ulpb_power_sequencer : scoreboard bench, expected output changes queued
// Revision 1.0 - initial release
// ============================================================================
module tb_ulpb_power_sequencer;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic WAKEUP_REQ = 1'b0;
  logic SLEEP_REQ = 1'b0;
  logic POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO;
  logic WAKE_DONE, SLEEP_DONE, BUSY;

  ulpb_power_sequencer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WAKEUP_REQ  (WAKEUP_REQ),
    .SLEEP_REQ   (SLEEP_REQ),
    .POWER_ON    (POWER_ON),
    .RELEASE_CLK (RELEASE_CLK),
    .RELEASE_RST (RELEASE_RST),
    .RELEASE_ISO (RELEASE_ISO),
    .WAKE_DONE   (WAKE_DONE),
    .SLEEP_DONE  (SLEEP_DONE),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  // Vector order: {POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO, WAKE_DONE, SLEEP_DONE, BUSY}
  localparam logic [6:0] V_OFF      = 7'b0000000;
  localparam logic [6:0] V_PWR      = 7'b1000001;
  localparam logic [6:0] V_CLK      = 7'b1100001;
  localparam logic [6:0] V_RST      = 7'b1110001;
  localparam logic [6:0] V_WAKE     = 7'b1111100;
  localparam logic [6:0] V_WAKE_PND = 7'b1111101;
  localparam logic [6:0] V_ACT      = 7'b1111000;
  localparam logic [6:0] V_SDONE    = 7'b0000010;
  localparam logic [6:0] V_SDONE_PND= 7'b0000011;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         sb_on = 1'b0;
  logic [6:0] prev_vec = '0;
  logic       prev_rst = 1'b1;
  ev_t        mon_ev;
  logic [6:0] mon_vec;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [6:0] outv();
    return {POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO, WAKE_DONE, SLEEP_DONE, BUSY};
  endfunction

  task automatic expect_ev(input int at, input logic [6:0] v);
    ev_t e;
    e.cyc = at;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic push_wake(input int b);
    expect_ev(b + 1,  V_PWR);
    expect_ev(b + 5,  V_CLK);
    expect_ev(b + 8,  V_RST);
    expect_ev(b + 11, V_WAKE);
    expect_ev(b + 12, V_ACT);
  endtask

  task automatic push_sleep(input int b);
    expect_ev(b + 1,  V_RST);
    expect_ev(b + 3,  V_CLK);
    expect_ev(b + 6,  V_PWR);
    expect_ev(b + 9,  V_SDONE);
    expect_ev(b + 10, V_OFF);
  endtask

  // Drive requests so that they are sampled by absolute edge e
  task automatic req_at(input int e, input logic w, input logic s);
    while (cyc < e - 1) @(negedge CLK);
    WAKEUP_REQ = w;
    SLEEP_REQ  = s;
    @(negedge CLK);
    WAKEUP_REQ = 1'b0;
    SLEEP_REQ  = 1'b0;
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d events still pending after %0d cycles, want 0", name, exp_q.size(), limit);
      exp_q.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  // Monitor: ordering invariants every cycle, scoreboard on every output change
  always @(negedge CLK) begin
    mon_vec = outv();
    total++;
    if ((mon_vec[3] && !mon_vec[4]) || (mon_vec[4] && !mon_vec[5]) || (mon_vec[5] && !mon_vec[6])) begin
      bad++;
      $display("FAIL order @%0d: controls %b violate iso->rst->clk->pwr", cyc, mon_vec[6:3]);
    end
    if (!RESET && !prev_rst) begin
      total++;
      if ($countones(mon_vec[6:3] ^ prev_vec[6:3]) > 1) begin
        bad++;
        $display("FAIL one_change @%0d: controls %b -> %b, want at most one toggle", cyc, prev_vec[6:3], mon_vec[6:3]);
      end
    end
    if (sb_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_ev = exp_q.pop_front();
        total++;
        bad++;
        $display("FAIL missed @%0d: outputs still %b, want %b at cycle %0d", cyc, mon_vec, mon_ev.vec, mon_ev.cyc);
      end
      if (mon_vec != prev_vec) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected @%0d: outputs %b -> %b, want no change", cyc, prev_vec, mon_vec);
        end else begin
          mon_ev = exp_q.pop_front();
          if (mon_ev.cyc != cyc || mon_ev.vec != mon_vec) begin
            bad++;
            $display("FAIL event: got %b at cycle %0d, want %b at cycle %0d", mon_vec, cyc, mon_ev.vec, mon_ev.cyc);
          end
        end
      end
    end
    prev_vec = mon_vec;
    prev_rst = RESET;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    #1 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RESET = 1'b0;
    @(negedge CLK);
    check("reset_state", outv(), V_OFF);
    sb_on = 1'b1;

    // Plain wake, then plain sleep
    b = cyc + 1;
    push_wake(b);
    req_at(b, 1'b1, 1'b0);
    drain("wake", 40);

    b = cyc + 1;
    push_sleep(b);
    req_at(b, 1'b0, 1'b1);
    drain("sleep", 40);

    // Sleep queued during wake; both-high mid-sequence keeps the pend flag
    b = cyc + 1;
    expect_ev(b + 1,  V_PWR);
    expect_ev(b + 5,  V_CLK);
    expect_ev(b + 8,  V_RST);
    expect_ev(b + 11, V_WAKE_PND);
    expect_ev(b + 12, V_RST);
    expect_ev(b + 14, V_CLK);
    expect_ev(b + 17, V_PWR);
    expect_ev(b + 20, V_SDONE);
    expect_ev(b + 21, V_OFF);
    req_at(b, 1'b1, 1'b0);
    req_at(b + 3, 1'b0, 1'b1);
    req_at(b + 5, 1'b1, 1'b1);
    drain("sleep_pend", 50);

    // Sleep in ASLEEP is ignored
    req_at(cyc + 1, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    check("asleep_sleep_ignored", outv(), V_OFF);

    // Both requests in ASLEEP: wake wins
    b = cyc + 1;
    push_wake(b);
    req_at(b, 1'b1, 1'b1);
    drain("both_asleep", 40);

    // Wake in ACTIVE is ignored
    req_at(cyc + 1, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    check("active_wake_ignored", outv(), V_ACT);

    // Both in ACTIVE: sleep wins; wake queued during ISO_DN
    b = cyc + 1;
    expect_ev(b + 1,  V_RST);
    expect_ev(b + 3,  V_CLK);
    expect_ev(b + 6,  V_PWR);
    expect_ev(b + 9,  V_SDONE_PND);
    expect_ev(b + 10, V_PWR);
    expect_ev(b + 14, V_CLK);
    expect_ev(b + 17, V_RST);
    expect_ev(b + 20, V_WAKE);
    expect_ev(b + 21, V_ACT);
    req_at(b, 1'b1, 1'b1);
    req_at(b + 2, 1'b1, 1'b0);
    drain("wake_pend", 50);

    // A later same-direction request cancels the queued wake
    b = cyc + 1;
    push_sleep(b);
    req_at(b, 1'b0, 1'b1);
    req_at(b + 2, 1'b1, 1'b0);
    req_at(b + 4, 1'b0, 1'b1);
    drain("last_wins", 40);

    // Asynchronous reset mid-wake, then a fresh wake
    b = cyc + 1;
    expect_ev(b + 1, V_PWR);
    expect_ev(b + 5, V_CLK);
    req_at(b, 1'b1, 1'b0);
    while (cyc < b + 6) @(negedge CLK);
    expect_ev(b + 7, V_OFF);
    #2 RESET = 1'b1;
    #1 check("async_reset", outv(), V_OFF);
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    b = cyc + 1;
    push_wake(b);
    req_at(b, 1'b1, 1'b0);
    drain("wake_after_reset", 40);

    // Random request stream; the monitor keeps checking the invariants
    sb_on = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      WAKEUP_REQ = ($urandom_range(0, 9) == 0);
      SLEEP_REQ  = ($urandom_range(0, 9) == 0);
    end
    @(negedge CLK);
    WAKEUP_REQ = 1'b0;
    SLEEP_REQ  = 1'b0;
    repeat (40) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
